mem_arbiter: RTL

- Shares the single-ported RAM between the instruction-fetch requester (iREN from the control unit's iMemRe) and the data requester (dREN/dWEN from dMemRe/dMemWr).
- Arbitrates between them, sequences each RAM transaction and returns wait/load signals to the datapath.
- Drains outstanding data traffic on Halt, then parks.
- Watchdog flags a hung RAM.

---
 rtl/cpu_types_pkg.sv | 23 ++
 rtl/mem_arb_wdog.sv | 28 ++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, arbiter FSM states and the machine word.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE,
        DGNT,
        IGNT,
        HALTED,
        ERR
    } arb_state_t;

endpackage

// File: rtl/mem_arb_wdog.sv
// Grant watchdog: counts stalled grant cycles and raises term once TIMEOUT-1 is reached.
module mem_arb_wdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic term
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_reg;

    // Saturates at LAST so a stuck grant cannot wrap back to a non-terminal count.
    always_ff @(posedge clk) begin
        if (srst || clr) begin
            cnt_reg <= '0;
        end else if (en && (cnt_reg != LAST)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign term = (cnt_reg == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter for the single-ported RAM, with halt drain and hung-RAM watchdog.
// Optional MEM_ARBITER_STATS_EN adds grant and stall counters.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic [DATA_W-1:0] dload,
    output logic              dwait,
    input  logic              halt,
    output logic              halted,
    output logic              err,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
`ifdef MEM_ARBITER_STATS_EN
    ,
    output word_t             stat_igrants,
    output word_t             stat_dgrants,
    output word_t             stat_stalls
`endif
);

    arb_state_t state_reg, state_next;
    logic       last_d_reg, last_d_next;
    ramstate_t  rs;
    logic       dreq;
    logic       grant;
    logic       icomplete, dcomplete;
    logic       wdog_term;

    assign rs    = ramstate_t'(ramstate);
    assign dreq  = dREN | dWEN;
    assign grant = (state_reg == DGNT) || (state_reg == IGNT);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            last_d_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            last_d_reg <= last_d_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        last_d_next = last_d_reg;
        iwait       = 1'b1;
        dwait       = 1'b1;
        iload       = '0;
        dload       = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        icomplete   = 1'b0;
        dcomplete   = 1'b0;

        case (state_reg)
            IDLE: begin
                // Data wins unless it was served last and an instruction fetch is waiting.
                if (dreq && !(last_d_reg && iREN && !halt)) begin
                    state_next = DGNT;
                end else if (iREN && !halt) begin
                    state_next = IGNT;
                end else if (halt) begin
                    state_next = HALTED;
                end
            end

            DGNT: begin
                ramaddr = daddr;
                if (dWEN) begin
                    ramWEN   = 1'b1;
                    ramstore = dstore;
                end else if (dREN) begin
                    ramREN = 1'b1;
                end

                if (rs == ERROR) begin
                    state_next = ERR;
                end else if (!dreq) begin
                    state_next = IDLE;
                end else if (rs == ACCESS) begin
                    dwait       = 1'b0;
                    dload       = ramload;
                    dcomplete   = 1'b1;
                    last_d_next = 1'b1;
                    state_next  = IDLE;
                end else if (wdog_term) begin
                    state_next = ERR;
                end
            end

            IGNT: begin
                ramaddr = iaddr;
                ramREN  = iREN;

                if (rs == ERROR) begin
                    state_next = ERR;
                end else if (!iREN) begin
                    state_next = IDLE;
                end else if (rs == ACCESS) begin
                    iwait       = 1'b0;
                    iload       = ramload;
                    icomplete   = 1'b1;
                    last_d_next = 1'b0;
                    state_next  = IDLE;
                end else if (wdog_term) begin
                    state_next = ERR;
                end
            end

            HALTED: state_next = HALTED;
            ERR:    state_next = ERR;
            default: state_next = IDLE;
        endcase
    end

    assign halted = (state_reg == HALTED);
    assign err    = (state_reg == ERR);

    mem_arb_wdog #(
        .TIMEOUT(TIMEOUT)
    ) u_wdog (
        .clk  (CLK),
        .srst (RST),
        .clr  (!grant || icomplete || dcomplete),
        .en   (grant && (rs != ACCESS)),
        .term (wdog_term)
    );

`ifdef MEM_ARBITER_STATS_EN
    logic [2:0] stat_inc;

    // Bit order: instruction completions, data completions, stalled request cycles.
    assign stat_inc = {(iREN | dreq) && !(icomplete || dcomplete), dcomplete, icomplete};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stat
        word_t cnt_reg;
        always_ff @(posedge CLK) begin
            if (RST) begin
                cnt_reg <= '0;
            end else if (stat_inc[gi]) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign stat_igrants = g_stat[0].cnt_reg;
    assign stat_dgrants = g_stat[1].cnt_reg;
    assign stat_stalls  = g_stat[2].cnt_reg;
`endif

endmodule
